div_32bit_seq: RTL

Sequential 32-bit signed integer divider that consumes the ALU's bitwise-inversion path. Every partial-remainder subtraction and every operand/result negation is formed as X + ~Y + 1 using a 32-bit one's-complement stage followed by an adder. The block sits beside the ALU in the execute stage. It accepts a start pulse and operands, iterates one quotient bit per clock, and returns a quotient with a one-cycle ready pulse and an exception flag.

---
 rtl/div_32bit_seq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/div_32bit_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div_32bit_seq
//  Purpose  : Sequential 32-bit signed restoring divider, one quotient bit
//             per clock. Subtractions and negations use X + ~Y + 1.
//  Revision : 1.0  initial release
// ============================================================================
module div_32bit_seq (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_q;       // dividend shifts out of the top, quotient enters at bit 0
  logic [32:0] r_rem;     // 33 bits so a 0x80000000 magnitude never loses its MSB
  logic [31:0] r_absB;
  logic [4:0]  r_cnt;
  logic        r_sA;
  logic        r_sB;
  logic        r_divz;
  logic        r_ovf;

  // Operand magnitudes: one's-complement stage then +1
  logic [31:0] w_invA, w_invB, w_absA, w_absB;
  assign w_invA = ~data_operandA;
  assign w_invB = ~data_operandB;
  assign w_absA = data_operandA[31] ? (w_invA + 32'd1) : data_operandA;
  assign w_absB = data_operandB[31] ? (w_invB + 32'd1) : data_operandB;

  // Shifted remainder and trial subtraction at 33 bits
  logic [32:0] w_rem_sh, w_invD, w_trial;
  assign w_rem_sh = {r_rem[31:0], r_q[31]};
  assign w_invD   = ~{1'b0, r_absB};
  assign w_trial  = w_rem_sh + w_invD + 33'd1;

  // Final sign correction of the magnitude quotient
  logic [31:0] w_invQ, w_signed_q;
  assign w_invQ     = ~r_q;
  assign w_signed_q = (r_sA ^ r_sB) ? (w_invQ + 32'd1) : r_q;

  // State register
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next-state logic; a start pulse wins from every state
  always_comb begin
    w_next = r_state;
    if (ctrl_DIV) begin
      w_next = (data_operandB == 32'd0) ? S_DONE : S_RUN;
    end else begin
      case (r_state)
        S_IDLE:  w_next = S_IDLE;
        S_RUN:   w_next = (r_cnt == 5'd31) ? S_DONE : S_RUN;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Datapath: latch operands on start, otherwise iterate while running
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      r_q    <= 32'd0;
      r_rem  <= 33'd0;
      r_absB <= 32'd0;
      r_cnt  <= 5'd0;
      r_sA   <= 1'b0;
      r_sB   <= 1'b0;
      r_divz <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (ctrl_DIV) begin
      r_q    <= w_absA;
      r_rem  <= 33'd0;
      r_absB <= w_absB;
      r_cnt  <= 5'd0;
      r_sA   <= data_operandA[31];
      r_sB   <= data_operandB[31];
      r_divz <= (data_operandB == 32'd0);
      r_ovf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 5'd1;
      if (!w_trial[32]) begin
        r_rem <= w_trial;
        r_q   <= {r_q[30:0], 1'b1};
      end else begin
        r_rem <= w_rem_sh;
        r_q   <= {r_q[30:0], 1'b0};
      end
    end
  end

  // Registered outputs follow the state one edge later; result captured from DONE
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= (r_state == S_DONE);
      busy           <= (r_state == S_RUN);
      if (r_state == S_DONE) begin
        data_result    <= r_divz ? 32'd0 : w_signed_q;
        data_exception <= r_divz | r_ovf;
      end
    end
  end

endmodule
`default_nettype wire
